lockin_result_fifo: RTL

- Downstream consumer of the lock-in filter stage.
- Takes the independent phase (X) and quadrature (Y) 64-bit result streams and pairs them into one {X,Y} record.
- Buffers records in a first-word-fall-through FIFO and presents them on a valid/ready stream to the readout / HPS bridge.
- Flags pairing desynchronisation and overflow so software can detect lost results.

---
 rtl/lockin_result_fifo.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lockin_result_fifo.sv
// Pairs the lock-in X/Y result streams into {X,Y} records and buffers them in a
// first-word-fall-through FIFO. Optional macro: LOCKIN_RESULT_TIMESTAMP_EN.
module lockin_result_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear,
    input  logic [63:0]   data_in_fase,
    input  logic          data_in_fase_valid,
    input  logic [63:0]   data_in_cuad,
    input  logic          data_in_cuad_valid,
    output logic [63:0]   out_fase,
    output logic [63:0]   out_cuad,
    output logic [31:0]   out_timestamp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   fill_level,
    output logic [31:0]   pair_count,
    output logic [15:0]   dropped_count,
    output logic          overflow,
    output logic          desync
);

    logic [63:0] hold_x_q, hold_x_d, hold_y_q, hold_y_d;
    logic        hold_x_vld_q, hold_x_vld_d, hold_y_vld_q, hold_y_vld_d;
    logic [63:0] pair_x_q, pair_x_d, pair_y_q, pair_y_d;
    logic        pair_vld_q, pair_vld_d;
    logic        desync_q, desync_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] fill_q, fill_d;
    logic [31:0] pair_count_q, pair_count_d;
    logic [15:0] dropped_q, dropped_d;
    logic        overflow_q, overflow_d;

    logic        x_vld, y_vld;
    logic        fifo_full, fifo_empty, rd_en, wr_en, drop;

    logic [63:0] mem_x [DEPTH];
    logic [63:0] mem_y [DEPTH];

    assign x_vld = enable & data_in_fase_valid;
    assign y_vld = enable & data_in_cuad_valid;

    // Channel pairing: at most one channel is ever held, so the held one decides the partner.
    always_comb begin
        hold_x_d     = hold_x_q;
        hold_x_vld_d = hold_x_vld_q;
        hold_y_d     = hold_y_q;
        hold_y_vld_d = hold_y_vld_q;
        pair_x_d     = pair_x_q;
        pair_y_d     = pair_y_q;
        pair_vld_d   = 1'b0;
        desync_d     = desync_q;
        if (clear) begin
            hold_x_d     = 64'd0;
            hold_x_vld_d = 1'b0;
            hold_y_d     = 64'd0;
            hold_y_vld_d = 1'b0;
            pair_x_d     = 64'd0;
            pair_y_d     = 64'd0;
            desync_d     = 1'b0;
        end else if (x_vld && y_vld) begin
            pair_vld_d = 1'b1;
            if (hold_x_vld_q) begin
                pair_x_d = hold_x_q;
                pair_y_d = data_in_cuad;
                hold_x_d = data_in_fase;
            end else if (hold_y_vld_q) begin
                pair_x_d = data_in_fase;
                pair_y_d = hold_y_q;
                hold_y_d = data_in_cuad;
            end else begin
                pair_x_d = data_in_fase;
                pair_y_d = data_in_cuad;
            end
        end else if (x_vld) begin
            if (hold_y_vld_q) begin
                pair_vld_d   = 1'b1;
                pair_x_d     = data_in_fase;
                pair_y_d     = hold_y_q;
                hold_y_vld_d = 1'b0;
            end else begin
                desync_d     = desync_q | hold_x_vld_q;
                hold_x_d     = data_in_fase;
                hold_x_vld_d = 1'b1;
            end
        end else if (y_vld) begin
            if (hold_x_vld_q) begin
                pair_vld_d   = 1'b1;
                pair_x_d     = hold_x_q;
                pair_y_d     = data_in_cuad;
                hold_x_vld_d = 1'b0;
            end else begin
                desync_d     = desync_q | hold_y_vld_q;
                hold_y_d     = data_in_cuad;
                hold_y_vld_d = 1'b1;
            end
        end else begin
            pair_vld_d = 1'b0;
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en      = ~fifo_empty & out_ready;
    // A read at full frees the slot on the same edge, so the write still lands.
    assign wr_en      = pair_vld_q & (~fifo_full | rd_en);
    assign drop       = pair_vld_q & fifo_full & ~rd_en;

    // FIFO pointers, occupancy and statistics.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        pair_count_d = pair_count_q;
        dropped_d    = dropped_q;
        overflow_d   = overflow_q;
        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fill_d       = '0;
            pair_count_d = 32'd0;
            dropped_d    = 16'd0;
            overflow_d   = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (wr_en && !rd_en) begin
                fill_d = fill_q + (AW+1)'(1);
            end else if (rd_en && !wr_en) begin
                fill_d = fill_q - (AW+1)'(1);
            end else begin
                fill_d = fill_q;
            end
            if (pair_vld_q) begin
                pair_count_d = pair_count_q + 32'd1;
            end else begin
                pair_count_d = pair_count_q;
            end
            if (drop) begin
                overflow_d = 1'b1;
                dropped_d  = (dropped_q == 16'hFFFF) ? dropped_q : dropped_q + 16'd1;
            end else begin
                overflow_d = overflow_q;
                dropped_d  = dropped_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_x_q     <= 64'd0;
            hold_x_vld_q <= 1'b0;
            hold_y_q     <= 64'd0;
            hold_y_vld_q <= 1'b0;
            pair_x_q     <= 64'd0;
            pair_y_q     <= 64'd0;
            pair_vld_q   <= 1'b0;
            desync_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            pair_count_q <= 32'd0;
            dropped_q    <= 16'd0;
            overflow_q   <= 1'b0;
        end else begin
            hold_x_q     <= hold_x_d;
            hold_x_vld_q <= hold_x_vld_d;
            hold_y_q     <= hold_y_d;
            hold_y_vld_q <= hold_y_vld_d;
            pair_x_q     <= pair_x_d;
            pair_y_q     <= pair_y_d;
            pair_vld_q   <= pair_vld_d;
            desync_q     <= desync_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            pair_count_q <= pair_count_d;
            dropped_q    <= dropped_d;
            overflow_q   <= overflow_d;
        end
    end

    // Record storage; contents are masked at the outputs while empty, so no reset.
    always_ff @(posedge clock) begin
        if (wr_en && !clear) begin
            mem_x[wr_ptr_q[AW-1:0]] <= pair_x_q;
            mem_y[wr_ptr_q[AW-1:0]] <= pair_y_q;
        end
    end

    assign out_valid     = ~fifo_empty;
    assign out_fase      = fifo_empty ? 64'd0 : mem_x[rd_ptr_q[AW-1:0]];
    assign out_cuad      = fifo_empty ? 64'd0 : mem_y[rd_ptr_q[AW-1:0]];
    assign fill_level    = fill_q;
    assign pair_count    = pair_count_q;
    assign dropped_count = dropped_q;
    assign overflow      = overflow_q;
    assign desync        = desync_q;

`ifdef LOCKIN_RESULT_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] mem_ts [DEPTH];

    assign ts_d = clear ? 32'd0 : ts_q + 32'd1;

    // Free-running capture clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q <= 32'd0;
        end else begin
            ts_q <= ts_d;
        end
    end

    // Timestamp stored alongside the record on its write cycle.
    always_ff @(posedge clock) begin
        if (wr_en && !clear) begin
            mem_ts[wr_ptr_q[AW-1:0]] <= ts_q;
        end
    end

    assign out_timestamp = fifo_empty ? 32'd0 : mem_ts[rd_ptr_q[AW-1:0]];
`else
    assign out_timestamp = 32'd0;
`endif

endmodule
